// File: rtl/bist_scheduler.sv
// Sequencer that time-shares one TPG/ORA/comparator datapath across NUM_CUT
// circuits-under-test, collecting a per-CUT fail bit and an overall verdict.
module bist_scheduler #(
  parameter int NUM_CUT = 4,
  parameter int NUM_PAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_CUT-1:0] cut_mask,
  input  logic               result,
  output logic [((NUM_CUT > 1) ? $clog2(NUM_CUT) : 1)-1:0] cut_sel,
  output logic               init,
  output logic               en,
  output logic               compare,
  output logic               busy,
  output logic               done,
  output logic               pass_fail,
  output logic [NUM_CUT-1:0] fail_map
);

  localparam int SEL_W = (NUM_CUT > 1) ? $clog2(NUM_CUT) : 1;
  localparam int PAT_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CUT - 1);
  localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(NUM_PAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_INIT    = 3'd2,
    ST_RUN     = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [SEL_W-1:0]   cut_sel_r, cut_sel_nxt_s;
  logic [PAT_W-1:0]   pat_cnt_r, pat_cnt_nxt_s;
  logic [NUM_CUT-1:0] mask_r, mask_nxt_s;
  logic [NUM_CUT-1:0] fail_map_r, fail_map_nxt_s;
  logic               init_r, en_r, compare_r, busy_r, done_r, pass_fail_r;

  // Next-state and datapath-control decode; abort overrides every busy transition.
  always_comb begin
    state_nxt_s    = state_r;
    cut_sel_nxt_s  = cut_sel_r;
    pat_cnt_nxt_s  = pat_cnt_r;
    mask_nxt_s     = mask_r;
    fail_map_nxt_s = fail_map_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mask_nxt_s     = cut_mask;
          fail_map_nxt_s = {NUM_CUT{1'b0}};
          cut_sel_nxt_s  = {SEL_W{1'b0}};
          state_nxt_s    = ST_SELECT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_SELECT: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (mask_r[cut_sel_r]) begin
          state_nxt_s = ST_INIT;
        end else if (cut_sel_r == LAST_SEL) begin
          state_nxt_s = ST_DONE;
        end else begin
          cut_sel_nxt_s = cut_sel_r + SEL_W'(1);
        end
      end
      ST_INIT: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          pat_cnt_nxt_s = {PAT_W{1'b0}};
          state_nxt_s   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          pat_cnt_nxt_s = pat_cnt_r + PAT_W'(1);
          if (pat_cnt_r == LAST_PAT) begin
            state_nxt_s = ST_COMPARE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_COMPARE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          fail_map_nxt_s[cut_sel_r] = ~result;
          if (cut_sel_r == LAST_SEL) begin
            state_nxt_s = ST_DONE;
          end else begin
            cut_sel_nxt_s = cut_sel_r + SEL_W'(1);
            state_nxt_s   = ST_SELECT;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, bookkeeping and strobes; strobes decode the next state so they track state_r exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cut_sel_r   <= {SEL_W{1'b0}};
      pat_cnt_r   <= {PAT_W{1'b0}};
      mask_r      <= {NUM_CUT{1'b0}};
      fail_map_r  <= {NUM_CUT{1'b0}};
      init_r      <= 1'b0;
      en_r        <= 1'b0;
      compare_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_fail_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cut_sel_r   <= cut_sel_nxt_s;
      pat_cnt_r   <= pat_cnt_nxt_s;
      mask_r      <= mask_nxt_s;
      fail_map_r  <= fail_map_nxt_s;
      init_r      <= (state_nxt_s == ST_INIT);
      en_r        <= (state_nxt_s == ST_RUN);
      compare_r   <= (state_nxt_s == ST_COMPARE);
      busy_r      <= (state_nxt_s == ST_SELECT) || (state_nxt_s == ST_INIT) ||
                     (state_nxt_s == ST_RUN)    || (state_nxt_s == ST_COMPARE);
      done_r      <= (state_nxt_s == ST_DONE);
      pass_fail_r <= (state_nxt_s == ST_DONE) && (fail_map_nxt_s == {NUM_CUT{1'b0}});
    end
  end

  assign cut_sel   = cut_sel_r;
  assign init      = init_r;
  assign en        = en_r;
  assign compare   = compare_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass_fail = pass_fail_r;
  assign fail_map  = fail_map_r;

endmodule

// File: tb/tb_bist_scheduler.sv
// Directed bench for bist_scheduler (NUM_CUT=4, NUM_PAT=3): run timing,
// per-CUT strobes, fail recording, abort, restart and mid-run reset.
module tb_bist_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, abort, result;
  logic [3:0] cut_mask;
  logic [1:0] cut_sel;
  logic       init, en, compare, busy, done, pass_fail;
  logic [3:0] fail_map;

  int tests_run    = 0;
  int tests_failed = 0;
  int en_cnt[4];
  int init_cnt[4];
  int cmp_cnt[4];
  int sel_back;

  bist_scheduler #(.NUM_CUT(4), .NUM_PAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cut_mask(cut_mask),
    .result(result), .cut_sel(cut_sel), .init(init), .en(en), .compare(compare),
    .busy(busy), .done(done), .pass_fail(pass_fail), .fail_map(fail_map)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run and step until done, recording strobes per CUT index; the
  // comparator reports a mismatch only while CUT fail_cut is being compared.
  task automatic run_watch(input logic [3:0] m, input int fail_cut,
                           input int restart_at, output int cycles);
    int prev_sel;
    for (int i = 0; i < 4; i++) begin
      en_cnt[i] = 0; init_cnt[i] = 0; cmp_cnt[i] = 0;
    end
    sel_back = 0;
    prev_sel = 0;
    cut_mask = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    cut_mask = ~m;
    cycles = 0;
    while (done !== 1'b1 && cycles < 200) begin
      start = (cycles == restart_at) ? 1'b1 : 1'b0;
      if (en === 1'b1) en_cnt[cut_sel]++;
      if (init === 1'b1) init_cnt[cut_sel]++;
      if (compare === 1'b1) cmp_cnt[cut_sel]++;
      if (int'(cut_sel) < prev_sel) sel_back = 1;
      prev_sel = int'(cut_sel);
      result = (compare === 1'b1 && int'(cut_sel) == fail_cut) ? 1'b0 : 1'b1;
      tick();
      cycles++;
    end
    start = 1'b0;
    result = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; result = 1'b1; cut_mask = 4'b0000;
    tick();
    tick();
    tests_run++; if ({init, en, compare, busy, done, pass_fail} !== 6'b000000) begin tests_failed++; $display("FAIL reset_strobes: got %b expected 000000", {init, en, compare, busy, done, pass_fail}); end
    tests_run++; if (cut_sel !== 2'd0) begin tests_failed++; $display("FAIL reset_cut_sel: got %0d expected 0", cut_sel); end
    tests_run++; if (fail_map !== 4'b0000) begin tests_failed++; $display("FAIL reset_fail_map: got %b expected 0000", fail_map); end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_all_pass();
    int cyc;
    run_watch(4'b1111, -1, -1, cyc);
    tests_run++; if (cyc !== 24) begin tests_failed++; $display("FAIL all_pass_latency: got %0d expected 24", cyc); end
    tests_run++; if (pass_fail !== 1'b1) begin tests_failed++; $display("FAIL all_pass_pf: got %b expected 1", pass_fail); end
    tests_run++; if (fail_map !== 4'b0000) begin tests_failed++; $display("FAIL all_pass_map: got %b expected 0000", fail_map); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (en_cnt[i] !== 3 || init_cnt[i] !== 1 || cmp_cnt[i] !== 1) begin tests_failed++; $display("FAIL all_pass_strobes_cut%0d: got en=%0d init=%0d cmp=%0d expected 3/1/1", i, en_cnt[i], init_cnt[i], cmp_cnt[i]); end
    end
    tests_run++; if (sel_back !== 0) begin tests_failed++; $display("FAIL all_pass_sel_order: got %0d expected 0", sel_back); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL all_pass_busy: got %b expected 0", busy); end
    repeat (3) tick();
    tests_run++; if ({done, pass_fail, fail_map} !== 6'b110000) begin tests_failed++; $display("FAIL done_frozen: got %b expected 110000", {done, pass_fail, fail_map}); end
  endtask

  task automatic test_one_fail();
    int cyc;
    run_watch(4'b1111, 2, -1, cyc);
    tests_run++; if (cyc !== 24) begin tests_failed++; $display("FAIL one_fail_latency: got %0d expected 24", cyc); end
    tests_run++; if (fail_map !== 4'b0100) begin tests_failed++; $display("FAIL one_fail_map: got %b expected 0100", fail_map); end
    tests_run++; if (pass_fail !== 1'b0) begin tests_failed++; $display("FAIL one_fail_pf: got %b expected 0", pass_fail); end
  endtask

  task automatic test_sparse();
    int cyc;
    run_watch(4'b0101, -1, -1, cyc);
    tests_run++; if (cyc !== 14) begin tests_failed++; $display("FAIL sparse_latency: got %0d expected 14", cyc); end
    tests_run++; if (en_cnt[1] + init_cnt[1] + cmp_cnt[1] + en_cnt[3] + init_cnt[3] + cmp_cnt[3] !== 0) begin tests_failed++; $display("FAIL sparse_disabled_strobes: got %0d expected 0", en_cnt[1] + init_cnt[1] + cmp_cnt[1] + en_cnt[3] + init_cnt[3] + cmp_cnt[3]); end
    tests_run++; if (en_cnt[0] !== 3 || en_cnt[2] !== 3) begin tests_failed++; $display("FAIL sparse_en: got %0d/%0d expected 3/3", en_cnt[0], en_cnt[2]); end
    tests_run++; if ({pass_fail, fail_map} !== 5'b10000) begin tests_failed++; $display("FAIL sparse_result: got %b expected 10000", {pass_fail, fail_map}); end
  endtask

  task automatic test_empty();
    int cyc, total;
    run_watch(4'b0000, -1, -1, cyc);
    total = 0;
    for (int i = 0; i < 4; i++) total += en_cnt[i] + init_cnt[i] + cmp_cnt[i];
    tests_run++; if (cyc !== 4) begin tests_failed++; $display("FAIL empty_latency: got %0d expected 4", cyc); end
    tests_run++; if (total !== 0) begin tests_failed++; $display("FAIL empty_strobes: got %0d expected 0", total); end
    tests_run++; if ({pass_fail, fail_map} !== 5'b10000) begin tests_failed++; $display("FAIL empty_result: got %b expected 10000", {pass_fail, fail_map}); end
  endtask

  task automatic test_done_restart();
    int cyc;
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL restart_pre_done: got %b expected 1", done); end
    cut_mask = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++; if ({done, busy} !== 2'b01) begin tests_failed++; $display("FAIL restart_done_drop: got %b expected 01", {done, busy}); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    tests_run++; if (cyc !== 4) begin tests_failed++; $display("FAIL restart_latency: got %0d expected 4", cyc); end
  endtask

  task automatic test_abort();
    int cyc;
    cut_mask = 4'b1111;
    result = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cut_mask = 4'b0000;
    repeat (9) tick();
    tests_run++; if ({en, cut_sel} !== 3'b101) begin tests_failed++; $display("FAIL abort_pre_run: got en/sel %b expected 101", {en, cut_sel}); end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    result = 1'b1;
    tests_run++; if ({init, en, compare, busy, done, pass_fail} !== 6'b000000) begin tests_failed++; $display("FAIL abort_outputs: got %b expected 000000", {init, en, compare, busy, done, pass_fail}); end
    tests_run++; if (fail_map !== 4'b0001) begin tests_failed++; $display("FAIL abort_fail_map: got %b expected 0001", fail_map); end
    tests_run++; if (cut_sel !== 2'd1) begin tests_failed++; $display("FAIL abort_cut_sel: got %0d expected 1", cut_sel); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    tests_run++; if ({busy, done, cut_sel, fail_map} !== 8'b00010001) begin tests_failed++; $display("FAIL abort_idle_ignored: got %b expected 00010001", {busy, done, cut_sel, fail_map}); end
    run_watch(4'b1111, -1, -1, cyc);
    tests_run++; if (cyc !== 24 || en_cnt[0] !== 3) begin tests_failed++; $display("FAIL abort_rerun: got cyc=%0d en0=%0d expected 24/3", cyc, en_cnt[0]); end
    tests_run++; if ({pass_fail, fail_map} !== 5'b10000) begin tests_failed++; $display("FAIL abort_rerun_result: got %b expected 10000", {pass_fail, fail_map}); end
  endtask

  task automatic test_start_busy();
    int cyc;
    run_watch(4'b1111, 1, 8, cyc);
    tests_run++; if (cyc !== 24) begin tests_failed++; $display("FAIL start_busy_latency: got %0d expected 24", cyc); end
    tests_run++; if (fail_map !== 4'b0010) begin tests_failed++; $display("FAIL start_busy_map: got %b expected 0010", fail_map); end
  endtask

  task automatic test_rst_mid();
    cut_mask = 4'b1111;
    result = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    tests_run++; if ({en, busy, fail_map[0]} !== 3'b111) begin tests_failed++; $display("FAIL rst_mid_pre: got %b expected 111", {en, busy, fail_map[0]}); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if ({init, en, compare, busy, done, pass_fail, cut_sel, fail_map} !== 12'h000) begin tests_failed++; $display("FAIL rst_mid_async: got %b expected 000000000000", {init, en, compare, busy, done, pass_fail, cut_sel, fail_map}); end
    #2 rst = 1'b0;
    result = 1'b1;
    tick();
    tests_run++; if ({busy, done} !== 2'b00) begin tests_failed++; $display("FAIL rst_mid_idle: got %b expected 00", {busy, done}); end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_one_fail();
    test_sparse();
    test_empty();
    test_done_restart();
    test_abort();
    test_start_busy();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
